// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - round-robin owner arbiter and mux for the shared data bus
module data_bus_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    parameter int MAX_HOLD   = 8,
    localparam int OWNER_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int HOLD_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_release,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_drive_data,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [OWNER_W-1:0]            o_owner,
    output logic [DATA_WIDTH-1:0]         o_bus_data,
    output logic                          o_bus_valid,
    output logic                          o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_OWNED      = 2'd1,
        ST_TURNAROUND = 2'd2
    } state_t;

    state_t              r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [OWNER_W-1:0]  r_owner;
    logic [OWNER_W-1:0]  r_last_owner;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_timeout;

    logic                w_found;
    logic [OWNER_W-1:0]  w_winner;
    logic [NUM_REQ-1:0]  w_winner_onehot;
    logic                w_own_release;
    logic                w_own_req;
    logic                w_others_pending;
    logic [HOLD_W-1:0]   w_hold_inc;
    logic                w_forced;
    logic [DATA_WIDTH-1:0] w_bus_data;

    // Round-robin search starting just after the last owner, wrapping around
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && i_req[(int'(r_last_owner) + k) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = OWNER_W'((int'(r_last_owner) + k) % NUM_REQ);
            end
        end
    end

    assign w_winner_onehot = NUM_REQ'(1) << w_winner;

    // Only the current owner's release/req matter; anyone else requesting counts as pending
    assign w_own_release    = |(i_release & r_grant);
    assign w_own_req        = |(i_req & r_grant);
    assign w_others_pending = |(i_req & ~r_grant);

    // Saturating hold count; the edge that would reach MAX_HOLD ends a contested ownership
    assign w_hold_inc = (r_hold == HOLD_W'(MAX_HOLD)) ? r_hold : r_hold + HOLD_W'(1);
    assign w_forced   = (w_hold_inc == HOLD_W'(MAX_HOLD)) && w_others_pending;

    // Ownership FSM with registered grant, owner and timeout pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= OWNER_W'(NUM_REQ - 1);
            r_hold       <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_winner_onehot;
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_hold       <= '0;
                        r_state      <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (w_own_release || !w_own_req) begin
                        // Voluntary handover takes precedence over a coincident timeout
                        r_grant <= '0;
                        r_state <= ST_TURNAROUND;
                    end else if (w_forced) begin
                        r_grant   <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_TURNAROUND;
                    end else begin
                        r_hold <= w_hold_inc;
                    end
                end
                ST_TURNAROUND: begin
                    if (w_found) begin
                        r_grant      <= w_winner_onehot;
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_hold       <= '0;
                        r_state      <= ST_OWNED;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Single-source bus mux selected by the registered one-hot grant; zero when idle
    always_comb begin
        w_bus_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_bus_data = i_drive_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_grant     = r_grant;
    assign o_owner     = r_owner;
    assign o_bus_data  = w_bus_data;
    assign o_bus_valid = |r_grant;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - table-driven checks for data_bus_arbiter
module tb_data_bus_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic [3:0]  i_req;
    logic [3:0]  i_release;
    logic [63:0] i_drive_data;
    logic [3:0]  o_grant;
    logic [1:0]  o_owner;
    logic [15:0] o_bus_data;
    logic        o_bus_valid;
    logic        o_timeout;

    data_bus_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4), .MAX_HOLD(8)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req        (i_req),
        .i_release    (i_release),
        .i_drive_data (i_drive_data),
        .o_grant      (o_grant),
        .o_owner      (o_owner),
        .o_bus_data   (o_bus_data),
        .o_bus_valid  (o_bus_valid),
        .o_timeout    (o_timeout)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] rel;
        logic [3:0] grant;
        logic [1:0] owner;
        logic       tmo;
        string      name;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] src_data [4];
    int          n_vec;
    int          n_err;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic void add(input logic rst, input logic [3:0] req, input logic [3:0] rel,
                                input logic [3:0] grant, input logic [1:0] owner,
                                input logic tmo, input string name);
        vec_t v;
        v.rst = rst; v.req = req; v.rel = rel;
        v.grant = grant; v.owner = owner; v.tmo = tmo; v.name = name;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eo, input logic et);
        logic [15:0] eb;
        logic        ev;
        eb = (eg == 4'b0) ? 16'h0 : src_data[eo];
        ev = (eg != 4'b0);
        n_vec++;
        if (o_grant !== eg || o_owner !== eo || o_timeout !== et ||
            o_bus_data !== eb || o_bus_valid !== ev) begin
            n_err++;
            $display("FAIL %s: got grant=%b owner=%0d bus=%h valid=%b tmo=%b, want grant=%b owner=%0d bus=%h valid=%b tmo=%b",
                     name, o_grant, o_owner, o_bus_data, o_bus_valid, o_timeout, eg, eo, eb, ev, et);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        src_data[0] = 16'hA000;
        src_data[1] = 16'hB111;
        src_data[2] = 16'hBEEF;
        src_data[3] = 16'hD333;
        i_drive_data = {src_data[3], src_data[2], src_data[1], src_data[0]};
        i_reset   = 1'b1;
        i_req     = 4'b1111;
        i_release = 4'b0000;

        add(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, "reset_hold_a");
        add(1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 0, "reset_hold_b");
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rr_g0");
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rr_g0_hold");
        add(0, 4'b1111, 4'b0001, 4'b0000, 2'd0, 0, "rr_ta0");
        add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0, "rr_g1");
        add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0, "rr_g1_hold");
        add(0, 4'b1111, 4'b0010, 4'b0000, 2'd1, 0, "rr_ta1");
        add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0, "rr_g2");
        add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0, "rr_g2_hold");
        add(0, 4'b1111, 4'b0100, 4'b0000, 2'd2, 0, "rr_ta2");
        add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0, "rr_g3");
        add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0, "rr_g3_hold");
        add(0, 4'b1111, 4'b1000, 4'b0000, 2'd3, 0, "rr_ta3");
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, "rr_g0_again");
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "drop_ta");
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, "drop_idle");
        add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "single_ram");
        add(0, 4'b0100, 4'b0001, 4'b0100, 2'd2, 0, "nonowner_rel");
        add(0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 0, "single_ta");
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, "single_idle");
        add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, "pc_grant");
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0, "pc_ta");
        add(0, 4'b1001, 4'b0000, 4'b1000, 2'd3, 0, "ta_req");
        for (int k = 0; k < 7; k++)
            add(0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 0, "force_hold");
        add(0, 4'b1010, 4'b0000, 4'b0000, 2'd3, 1, "force_ta");
        add(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 0, "force_next");
        for (int k = 0; k < 7; k++)
            add(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 0, "both_hold");
        add(0, 4'b1010, 4'b0010, 4'b0000, 2'd1, 0, "both_ta");
        add(0, 4'b1010, 4'b0000, 4'b1000, 2'd3, 0, "both_next");
        add(0, 4'b0010, 4'b0000, 4'b0000, 2'd3, 0, "solo_ta");
        add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, "solo_g");
        for (int k = 0; k < 20; k++)
            add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, "solo_hold");
        add(0, 4'b0100, 4'b0000, 4'b0000, 2'd1, 0, "mid_ta");
        add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "mid_g");
        add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "mid_hold_a");
        add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0, "mid_hold_b");

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge i_clk);
            i_reset   = tbl[i].rst;
            i_req     = tbl[i].req;
            i_release = tbl[i].rel;
            @(posedge i_clk);
            #1;
            check(tbl[i].name, tbl[i].grant, tbl[i].owner, tbl[i].tmo);
        end

        // Asynchronous reset while requester 2 owns the bus
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check("reset_mid", 4'b0000, 2'd0, 1'b0);
        @(negedge i_clk);
        i_req   = 4'b0110;
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        check("post_reset_g", 4'b0010, 2'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
